// File: rtl/dcache_pkg.sv
// Shared types, access-mode encodings and helpers for the write-through data cache.
package dcache_pkg;

  typedef enum logic {IDLE, REFILL} dcache_state_t;

  localparam logic [2:0]  MODE_W  = 3'b001;
  localparam logic [2:0]  MODE_H  = 3'b010;
  localparam logic [2:0]  MODE_B  = 3'b011;
  localparam logic [2:0]  MODE_HU = 3'b100;
  localparam logic [2:0]  MODE_BU = 3'b101;

  localparam logic [31:0] TRIGGER_ADDR = 32'h100;

  // Bytes touched by an access; 0 marks an unsupported mode.
  function automatic logic [2:0] access_bytes(input logic [2:0] mode);
    case (mode)
      MODE_W:          access_bytes = 3'd4;
      MODE_H, MODE_HU: access_bytes = 3'd2;
      MODE_B, MODE_BU: access_bytes = 3'd1;
      default:         access_bytes = 3'd0;
    endcase
  endfunction

  function automatic logic mode_valid(input logic [2:0] mode);
    return access_bytes(mode) != 3'd0;
  endfunction

  function automatic logic crosses_word(input logic [2:0] mode, input logic [1:0] off);
    logic [2:0] nb;
    nb = access_bytes(mode);
    return (nb != 3'd0) && ((3'({1'b0, off}) + nb) > 3'd4);
  endfunction

endpackage

// File: rtl/dcache_wt_if.sv
// CPU-side request/response and data-memory signals of the write-through cache.
interface dcache_wt_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [2:0]       cpu_mode;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wd;
  logic [WIDTH-1:0] cpu_rd;
  logic             cpu_stall;
  logic [2:0]       mem_mode;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wd;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rd;

  modport master (
    input  cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wd, mem_rd,
    output cpu_rd, cpu_stall, mem_mode, mem_addr, mem_wd, mem_we
  );

  modport slave (
    output cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wd, mem_rd,
    input  cpu_rd, cpu_stall, mem_mode, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/dcache_wt_load_extract.sv
// Selects the byte/half at a byte offset inside a little-endian word and extends it per mode.
module load_extract
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       off,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] result_c
);

  logic [WIDTH-1:0] shifted;

  assign shifted = word >> {off, 3'b000};

  always_comb begin
    result_c = '0;
    case (mode)
      MODE_W:  result_c = word;
      MODE_H:  result_c = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      MODE_HU: result_c = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      MODE_B:  result_c = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      MODE_BU: result_c = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      default: result_c = '0;
    endcase
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and data memory.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned NUM_LINES  = 64,
  parameter int unsigned ADDR_BITS  = 17
) (
  input logic        clk,
  input logic        rst_n,
  dcache_wt_if.master bus
);

  localparam int unsigned OFF_BITS = $clog2(4 * LINE_WORDS);
  localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = ADDR_BITS - OFF_BITS - IDX_BITS;
  localparam int unsigned CNT_BITS = $clog2(LINE_WORDS);

  dcache_state_t state_q, state_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [WIDTH-1:0]     data_q [NUM_LINES][LINE_WORDS];
  logic [CNT_BITS-1:0]  cnt_q;

  logic [ADDR_BITS-1:0] addr_a;
  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag_in;
  logic [CNT_BITS-1:0]  word_sel;
  logic [ADDR_BITS-1:0] refill_addr;
  logic [WIDTH-1:0]     hit_rd;
  logic                 hit;
  logic                 uncached;

  logic             stall_c, mem_we_c, fill_we, fill_done, inval;
  logic [2:0]       mem_mode_c;
  logic [WIDTH-1:0] cpu_rd_c, mem_addr_c, mem_wd_c;

  assign addr_a      = bus.cpu_addr[ADDR_BITS-1:0];
  assign idx         = addr_a[OFF_BITS +: IDX_BITS];
  assign tag_in      = addr_a[ADDR_BITS-1 -: TAG_BITS];
  assign word_sel    = addr_a[2 +: CNT_BITS];
  assign hit         = valid_q[idx] && (tag_q[idx] == tag_in);
  // Line base plus word counter; the tag field is never touched, so no carry can leak into it.
  assign refill_addr = {addr_a[ADDR_BITS-1:OFF_BITS], cnt_q, 2'b00};
  assign uncached    = (bus.cpu_addr == WIDTH'(TRIGGER_ADDR))
                    || crosses_word(bus.cpu_mode, addr_a[1:0]);

  load_extract #(.WIDTH(WIDTH)) u_extract (
    .word     (data_q[idx][word_sel]),
    .off      (addr_a[1:0]),
    .mode     (bus.cpu_mode),
    .result_c (hit_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Lookup, refill sequencing and memory-side drive.
  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    cpu_rd_c   = '0;
    mem_mode_c = 3'b000;
    mem_addr_c = '0;
    mem_wd_c   = '0;
    mem_we_c   = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    inval      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (uncached) begin
            mem_mode_c = bus.cpu_mode;
            mem_addr_c = bus.cpu_addr;
            mem_wd_c   = bus.cpu_wd;
            mem_we_c   = bus.cpu_we;
            cpu_rd_c   = bus.mem_rd;
          end else if (bus.cpu_we) begin
            mem_mode_c = bus.cpu_mode;
            mem_addr_c = bus.cpu_addr;
            mem_wd_c   = bus.cpu_wd;
            mem_we_c   = 1'b1;
            inval      = hit;
          end else if (mode_valid(bus.cpu_mode)) begin
            if (hit) begin
              cpu_rd_c = hit_rd;
            end else begin
              stall_c = 1'b1;
              state_d = REFILL;
            end
          end
        end
      end
      REFILL: begin
        stall_c    = 1'b1;
        mem_mode_c = MODE_W;
        mem_addr_c = WIDTH'(refill_addr);
        fill_we    = 1'b1;
        if (cnt_q == CNT_BITS'(LINE_WORDS - 1)) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (fill_we)   cnt_q <= fill_done ? '0 : cnt_q + CNT_BITS'(1);
      if (fill_done) valid_q[idx] <= 1'b1;
      if (inval)     valid_q[idx] <= 1'b0;
    end
  end

  // Payload arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (rst_n && fill_we) begin
      data_q[idx][cnt_q] <= bus.mem_rd;
      if (fill_done) tag_q[idx] <= tag_in;
    end
  end

  assign bus.cpu_rd    = cpu_rd_c;
  assign bus.cpu_stall = stall_c;
  assign bus.mem_mode  = mem_mode_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wd    = mem_wd_c;
  assign bus.mem_we    = mem_we_c;

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized self-checking bench for dcache_wt against a line-valid/tag model and a golden byte memory.
module tb_dcache_wt;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_wt_if #(.WIDTH(32)) bif();

  dcache_wt dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  logic [7:0]  mem_b [0:131071];
  logic [7:0]  ref_b [0:131071];
  logic        m_valid [64];
  logic [6:0]  m_tag   [64];
  int          n_checks = 0;
  int          n_errors = 0;

  // Data memory: combinational little-endian read, byte-masked write on posedge.
  logic [16:0] ma;
  assign ma = bif.mem_addr[16:0];
  assign bif.mem_rd = {mem_b[ma + 17'd3], mem_b[ma + 17'd2], mem_b[ma + 17'd1], mem_b[ma]};

  function automatic int nbytes(input logic [2:0] mode);
    case (mode)
      MODE_W:          return 4;
      MODE_H, MODE_HU: return 2;
      MODE_B, MODE_BU: return 1;
      default:         return 0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bif.mem_we)
      for (int i = 0; i < 4; i++)
        if (i < nbytes(bif.mem_mode)) mem_b[17'(ma + i)] <= bif.mem_wd[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] mode, input logic [16:0] a, input bit unc);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_b[a];
    b1 = ref_b[a + 17'd1];
    b2 = ref_b[a + 17'd2];
    b3 = ref_b[a + 17'd3];
    if (unc) return {b3, b2, b1, b0};
    case (mode)
      MODE_W:  return {b3, b2, b1, b0};
      MODE_H:  return {{16{b1[7]}}, b1, b0};
      MODE_HU: return {16'h0, b1, b0};
      MODE_B:  return {{24{b0[7]}}, b0};
      MODE_BU: return {24'h0, b0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // One request held until the cache releases it; expectations come from the model.
  task automatic access(input bit we, input logic [2:0] mode, input logic [31:0] addr, input logic [31:0] wd);
    logic [16:0] a;
    int          idx;
    logic [6:0]  tg;
    bit          unc, hit, fill;
    logic [31:0] exp_rd;
    logic [2:0]  exp_mm;
    int          cyc, k;
    a      = addr[16:0];
    idx    = int'(a[9:4]);
    tg     = a[16:10];
    unc    = (addr == 32'h100) || (nbytes(mode) != 0 && int'(a[1:0]) + nbytes(mode) > 4);
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    fill   = !unc && !we && nbytes(mode) != 0 && !hit;
    exp_rd = exp_load(mode, a, unc);
    exp_mm = (unc || we) ? mode : 3'b000;
    cyc = 0;
    k   = 0;
    @(negedge clk);
    bif.cpu_req  = 1'b1;
    bif.cpu_we   = we;
    bif.cpu_mode = mode;
    bif.cpu_addr = addr;
    bif.cpu_wd   = wd;
    #1;
    while (bif.cpu_stall && cyc < 20) begin
      if (bif.mem_mode == MODE_W) begin
        check("refill_addr", bif.mem_addr, 32'({a[16:4], 4'h0}) + 32'(4 * k));
        check("refill_we", 32'(bif.mem_we), 32'h0);
        k++;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
    check("stall_cycles", 32'(cyc), fill ? 32'd5 : 32'd0);
    check("refill_words", 32'(k), fill ? 32'd4 : 32'd0);
    if (!we) check("load_data", bif.cpu_rd, exp_rd);
    check("mem_we", 32'(bif.mem_we), 32'(we));
    check("mem_mode", 32'(bif.mem_mode), 32'(exp_mm));
    if (we || unc) check("mem_addr", bif.mem_addr, addr);
    if (we) check("mem_wd", bif.mem_wd, wd);
    @(posedge clk);
    if (fill) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    if (we && !unc && hit) m_valid[idx] = 1'b0;
    if (we)
      for (int i = 0; i < nbytes(mode); i++) ref_b[17'(a + i)] = wd[8*i +: 8];
  endtask

  task automatic idle();
    @(negedge clk);
    bif.cpu_req = 1'b0;
    bif.cpu_we  = 1'b0;
  endtask

  initial begin
    logic [2:0]  md;
    logic [31:0] ad, wdat;
    logic [6:0]  tags [4];
    bit          st;
    tags[0] = 7'd1; tags[1] = 7'd2; tags[2] = 7'd65; tags[3] = 7'd127;

    for (int i = 0; i < 131072; i++) begin
      mem_b[i] = 8'($urandom);
      ref_b[i] = mem_b[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem_b[32'h10000 + i] = 8'(32'hDEADBEEF >> (8 * i));
      ref_b[32'h10000 + i] = mem_b[32'h10000 + i];
      mem_b[32'h100 + i]   = (i == 0) ? 8'h01 : 8'h00;
      ref_b[32'h100 + i]   = mem_b[32'h100 + i];
    end
    clear_model();

    bif.cpu_req = 1'b0; bif.cpu_we = 1'b0; bif.cpu_mode = 3'b000;
    bif.cpu_addr = '0; bif.cpu_wd = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_stall", 32'(bif.cpu_stall), 32'h0);
    check("reset_rd", bif.cpu_rd, 32'h0);
    check("reset_mem_we", 32'(bif.mem_we), 32'h0);
    check("reset_mem_mode", 32'(bif.mem_mode), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    access(0, MODE_W, 32'h10000, 0);
    check("t1_constant", bif.cpu_rd, 32'hDEADBEEF);
    access(0, MODE_B,  32'h10000, 0);
    access(0, MODE_BU, 32'h10000, 0);
    access(0, MODE_H,  32'h10002, 0);
    access(0, MODE_HU, 32'h10002, 0);
    access(1, MODE_W,  32'h10004, $urandom);
    access(0, MODE_W,  32'h10004, 0);
    access(0, MODE_W,  32'h100,   0);
    access(0, MODE_H,  32'h10003, 0);
    access(0, MODE_W,  32'h10000, 0);
    access(0, MODE_W,  32'h80010008, 0);
    access(0, MODE_W,  32'h10000 + 32'(4 * 4 * 64), 0);
    access(0, MODE_W,  32'h10000, 0);
    access(0, MODE_B,  32'h10001, 0);
    access(1, MODE_H,  32'h10002, $urandom);
    access(0, MODE_H,  32'h10002, 0);
    idle();

    // Reset lands while the second refill word is being fetched.
    @(negedge clk);
    bif.cpu_req = 1'b1; bif.cpu_we = 1'b0; bif.cpu_mode = MODE_W; bif.cpu_addr = 32'h13000;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bif.cpu_req = 1'b0;
    #1;
    check("abort_stall", 32'(bif.cpu_stall), 32'h0);
    check("abort_mem_mode", 32'(bif.mem_mode), 32'h0);
    clear_model();
    access(0, MODE_W, 32'h13000, 0);
    access(0, MODE_W, 32'h10000, 0);

    for (int n = 0; n < 400; n++) begin
      ad = {15'h0, tags[$urandom_range(0, 3)], 6'($urandom_range(0, 7)), 4'($urandom)};
      if ($urandom_range(0, 3) == 0) ad[31:17] = 15'($urandom);
      st = ($urandom_range(0, 9) < 3);
      wdat = $urandom;
      if (st) begin
        case ($urandom_range(0, 2))
          0:       begin md = MODE_W; ad[1:0] = 2'b00; end
          1:       begin md = MODE_H; ad[0] = 1'b0; end
          default: md = MODE_B;
        endcase
      end else begin
        md = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 19) == 0) begin ad = 32'h100; md = MODE_W; end
      end
      access(st, md, ad, wdat);
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
